// File: rtl/reg_to_bus_rr_sel.sv
// Round-robin register-to-bus selector with a registered valid/ready output stage.
// Optional macro REG_BUS_PRIO0_EN gives register 0 absolute priority over the rotation.
module reg_to_bus_rr_sel #(
  parameter int WIDTH = 16,
  parameter int NREGS = 4,
  parameter int SELW  = 2
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [NREGS*WIDTH-1:0] REGS_IN,
  input  logic [NREGS-1:0]       REQ,
  input  logic                   BUS_READY,
  output logic [WIDTH-1:0]       TO_BUS,
  output logic                   BUS_VALID,
  output logic [NREGS-1:0]       GRANT,
  output logic [SELW-1:0]        SEL_OUT
);

  logic [SELW-1:0]  ptr;
  logic [SELW-1:0]  win;
  logic [SELW-1:0]  ptr_next;
  logic [WIDTH-1:0] win_data;
  logic             found;
  logic             prio_hit;
  logic             free;

  assign free = !BUS_VALID || BUS_READY;

  // Two ascending scans: indices at or above ptr first, then the wrapped-around
  // lower indices, which together give the first requester starting from ptr.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    found    = 1'b0;
    prio_hit = 1'b0;
    win      = '0;
    win_data = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (!found && REQ[i] && (i >= int'(ptr))) begin
        found    = 1'b1;
        win      = SELW'(i);
        win_data = REGS_IN[i*WIDTH +: WIDTH];
      end
    end
    for (int i = 0; i < NREGS; i++) begin
      if (!found && REQ[i]) begin
        found    = 1'b1;
        win      = SELW'(i);
        win_data = REGS_IN[i*WIDTH +: WIDTH];
      end
    end
`ifdef REG_BUS_PRIO0_EN
    if (REQ[0]) begin
      prio_hit = 1'b1;
      win      = '0;
      win_data = REGS_IN[WIDTH-1:0];
    end
`endif
    if (prio_hit)
      ptr_next = ptr;
    else if (int'(win) == NREGS - 1)
      ptr_next = '0;
    else
      ptr_next = win + 1'b1;
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      TO_BUS    <= '0;
      BUS_VALID <= 1'b0;
      GRANT     <= '0;
      SEL_OUT   <= '0;
      ptr       <= '0;
    end else begin
      GRANT <= '0;
      if (free) begin
        if (found) begin
          TO_BUS    <= win_data;
          SEL_OUT   <= win;
          BUS_VALID <= 1'b1;
          GRANT     <= NREGS'(1) << win;
          ptr       <= ptr_next;
        end else begin
          BUS_VALID <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_to_bus_rr_sel.sv
// Directed bench for reg_to_bus_rr_sel: a 4-register instance plus a 3-register
// instance that exercises pointer wrap at NREGS.
module tb_reg_to_bus_rr_sel;

  logic        CLK = 1'b0;
  logic        RST;

  logic [63:0] regs4;
  logic [3:0]  req4;
  logic        rdy4;
  logic [15:0] bus4;
  logic        val4;
  logic [3:0]  gnt4;
  logic [1:0]  sel4;

  logic [47:0] regs3;
  logic [2:0]  req3;
  logic        rdy3;
  logic [15:0] bus3;
  logic        val3;
  logic [2:0]  gnt3;
  logic [1:0]  sel3;

  int n_pass  = 0;
  int n_total = 0;

  always #5 CLK = ~CLK;

  reg_to_bus_rr_sel #(.WIDTH(16), .NREGS(4), .SELW(2)) dut4 (
    .CLK(CLK), .RST(RST), .REGS_IN(regs4), .REQ(req4), .BUS_READY(rdy4),
    .TO_BUS(bus4), .BUS_VALID(val4), .GRANT(gnt4), .SEL_OUT(sel4)
  );

  reg_to_bus_rr_sel #(.WIDTH(16), .NREGS(3), .SELW(2)) dut3 (
    .CLK(CLK), .RST(RST), .REGS_IN(regs3), .REQ(req3), .BUS_READY(rdy3),
    .TO_BUS(bus3), .BUS_VALID(val3), .GRANT(gnt3), .SEL_OUT(sel3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check4(input string tag, input logic [15:0] bus, input logic val,
                        input logic [3:0] gnt, input logic [1:0] sel);
    check({tag, ".bus"},   32'(bus4), 32'(bus));
    check({tag, ".valid"}, 32'(val4), 32'(val));
    check({tag, ".grant"}, 32'(gnt4), 32'(gnt));
    check({tag, ".sel"},   32'(sel4), 32'(sel));
  endtask

  initial begin
    RST   = 1'b1;
    req4  = 4'b1111;
    rdy4  = 1'b1;
    regs4 = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    req3  = 3'b000;
    rdy3  = 1'b1;
    regs3 = {16'hC3C3, 16'hB2B2, 16'hA1A1};

    // Reset held two cycles with all requests high: no grant, everything zero.
    step();
    check4("reset1", 16'h0, 1'b0, 4'b0000, 2'd0);
    step();
    check4("reset2", 16'h0, 1'b0, 4'b0000, 2'd0);
    check("reset.dut3_valid", 32'(val3), 32'd0);
    RST = 1'b0;

    // Fairness: all requests held, one grant per cycle in rotation.
    step(); check4("rr0", 16'h1111, 1'b1, 4'b0001, 2'd0);
    step(); check4("rr1", 16'h2222, 1'b1, 4'b0010, 2'd1);
    step(); check4("rr2", 16'h3333, 1'b1, 4'b0100, 2'd2);
    step(); check4("rr3", 16'h4444, 1'b1, 4'b1000, 2'd3);
    step(); check4("rr4", 16'h1111, 1'b1, 4'b0001, 2'd0);

    // Idle: valid drops, data and select hold.
    req4 = 4'b0000;
    step(); check4("idle", 16'h1111, 1'b0, 4'b0000, 2'd0);

    // Single request from register 2.
    regs4[2*16 +: 16] = 16'hA5C3;
    req4 = 4'b0100;
    step(); check4("single", 16'hA5C3, 1'b1, 4'b0100, 2'd2);
    req4 = 4'b0000;
    step(); check("single.release_valid", 32'(val4), 32'd0);

    // Stall: capture R1, then hold with BUS_READY low while its source changes.
    regs4[1*16 +: 16] = 16'h1234;
    req4 = 4'b0010;
    step(); check4("stall.capture", 16'h1234, 1'b1, 4'b0010, 2'd1);
    req4 = 4'b1000;
    rdy4 = 1'b0;
    regs4[1*16 +: 16] = 16'hFFFF;
    step(); check4("stall1", 16'h1234, 1'b1, 4'b0000, 2'd1);
    step(); check4("stall2", 16'h1234, 1'b1, 4'b0000, 2'd1);
    step(); check4("stall3", 16'h1234, 1'b1, 4'b0000, 2'd1);
    rdy4 = 1'b1;
    step(); check4("stall.release", 16'h4444, 1'b1, 4'b1000, 2'd3);
    req4 = 4'b0000;
    step(); check("stall.drain_valid", 32'(val4), 32'd0);

    // Registers 0 and 3 both held: alternate, or always 0 with priority.
    req4 = 4'b1001;
`ifdef REG_BUS_PRIO0_EN
    step(); check("pair0.grant", 32'(gnt4), 32'b0001);
    step(); check("pair1.grant", 32'(gnt4), 32'b0001);
    step(); check("pair2.grant", 32'(gnt4), 32'b0001);
    step(); check("pair3.grant", 32'(gnt4), 32'b0001);
`else
    step(); check("pair0.grant", 32'(gnt4), 32'b0001);
    step(); check("pair1.grant", 32'(gnt4), 32'b1000);
    step(); check("pair2.grant", 32'(gnt4), 32'b0001);
    step(); check("pair3.grant", 32'(gnt4), 32'b1000);
`endif

    // Reset during a stalled transfer discards the pending word.
    req4 = 4'b0000;
    rdy4 = 1'b0;
    step(); check("midrst.held_valid", 32'(val4), 32'd1);
    RST = 1'b1;
    step(); check4("midrst", 16'h0, 1'b0, 4'b0000, 2'd0);
    RST  = 1'b0;
    rdy4 = 1'b1;
    req4 = 4'b1000;
    step(); check4("midrst.after", 16'h4444, 1'b1, 4'b1000, 2'd3);
    req4 = 4'b0000;

    // Three-register instance: bring ptr to 2 with a grant to register 1, then wrap.
    req3 = 3'b010;
    step();
    check("w3.setup_grant", 32'(gnt3), 32'b010);
    req3 = 3'b011;
    step();
    check("w3.wrap_grant", 32'(gnt3), 32'b001);
    check("w3.wrap_sel",   32'(sel3), 32'd0);
    check("w3.wrap_bus",   32'(bus3), 32'hA1A1);
    step();
`ifdef REG_BUS_PRIO0_EN
    check("w3.next_grant", 32'(gnt3), 32'b001);
`else
    check("w3.next_grant", 32'(gnt3), 32'b010);
`endif
    req3 = 3'b100;
    step();
    check("w3.top_grant", 32'(gnt3), 32'b100);
    check("w3.top_sel",   32'(sel3), 32'd2);
    req3 = 3'b101;
    step();
    check("w3.ptr_wrapped_grant", 32'(gnt3), 32'b001);
    check("w3.ptr_wrapped_sel",   32'(sel3), 32'd0);
    req3 = 3'b000;
    step();
    check("w3.idle_valid", 32'(val3), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/reg_to_bus_rr_sel.md
Name: reg_to_bus_rr_sel

Overview:
- Parametrised successor of the 2:1 register-to-bus selector in the register bank.
- Selects one of NREGS registers onto a shared WIDTH-bit bus. Selection is by round-robin arbitration of per-register read requests.
- Output is registered, with a valid/ready handshake toward the bus consumer.
- Sits between the register bank outputs and the internal data bus. Replaces hard-wired SEL_BUS muxing with request-driven, fair sharing.

Parameters:
- WIDTH, 16: register and bus width in bits.
- NREGS, 4: number of source registers, 2..16; need not be a power of two.
- SELW, 2: width of SEL_OUT; must satisfy 2^SELW >= NREGS.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- REGS_IN  input  NREGS*WIDTH  packed register values; register i occupies bits [i*WIDTH +: WIDTH].
- REQ  input  NREGS  per-register read request; level, held by requester until granted.
- BUS_READY  input  1  consumer accepts TO_BUS this cycle when BUS_VALID=1.
- TO_BUS  output  WIDTH  registered bus data.
- BUS_VALID  output  1  TO_BUS holds an unaccepted word.
- GRANT  output  NREGS  one-hot, one-cycle pulse; identifies the register captured this cycle.
- SEL_OUT  output  SELW  index of the register currently on TO_BUS.

Behaviour:
- Reset, applied on the CLK edge when RST=1, has priority over everything. It sets:
  - TO_BUS=0
  - BUS_VALID=0
  - GRANT=0
  - SEL_OUT=0
  - internal round-robin pointer PTR=0
- Reset mid-transfer discards the pending word. No grant is issued in the reset cycle.
- Slot free condition: FREE = !BUS_VALID | BUS_READY, evaluated combinationally each cycle.
- Capture (FREE=1 and REQ!=0):
  - Winner W = first i with REQ[i]=1, scanning PTR, PTR+1, ..., wrapping mod NREGS.
  - Next edge: TO_BUS<=REGS_IN[W], SEL_OUT<=W, BUS_VALID<=1, GRANT<=(1<<W).
  - PTR<=(W+1) mod NREGS. Wrap at NREGS, not at 2^SELW.
- Idle (FREE=1 and REQ==0): BUS_VALID<=0, GRANT<=0. TO_BUS, SEL_OUT and PTR hold.
- Stall (BUS_VALID=1 and BUS_READY=0): TO_BUS, SEL_OUT, BUS_VALID and PTR hold; GRANT<=0. Requests stay pending and are not lost.
- Back-to-back: accept (BUS_READY=1) and new capture happen on the same edge. Sustained throughput is one word per cycle.
- Latency: REQ asserted with slot free -> TO_BUS/BUS_VALID/GRANT valid after exactly 1 CLK edge.
- Data is sampled at capture. Later changes to REGS_IN[W] do not affect TO_BUS while it is held.
- Requester release: a requester drops REQ on the cycle after seeing its GRANT.
  - A REQ still high after GRANT counts as a new request.
  - Round-robin places that requester last, so no starvation.
- GRANT is never asserted without a matching BUS_VALID=1 in the same cycle. GRANT is always zero or one-hot.
- SEL_OUT is only meaningful while BUS_VALID=1.

Optional Feature:
- Macro: REG_BUS_PRIO0_EN.
- Defined: register 0 has absolute priority. If REQ[0]=1 while FREE=1, W=0 regardless of PTR, and PTR is not updated. Other registers use round-robin as above when REQ[0]=0.
- Not defined: pure round-robin for all registers, with no special handling of index 0.

Test Plan:
- Reset: RST=1 for 2 cycles with REQ=4'b1111 -> TO_BUS=0, BUS_VALID=0, GRANT=0, SEL_OUT=0. After release, first grant is 4'b0001.
- Single request: REGS_IN[2]=16'hA5C3, REQ=4'b0100, BUS_READY=1 -> next cycle TO_BUS=16'hA5C3, SEL_OUT=2, GRANT=4'b0100, BUS_VALID=1.
- Fairness: REQ=4'b1111 held, BUS_READY=1 -> GRANT sequence 0001, 0010, 0100, 1000, 0001; BUS_VALID=1 every cycle.
- Stall: capture R1=16'h1234, then BUS_READY=0 for 3 cycles while REGS_IN[1] changes to 16'hFFFF -> TO_BUS stays 16'h1234, GRANT=0. Next grant occurs on the cycle BUS_READY=1.
- Wrap with NREGS=3, SELW=2: PTR=2, REQ=3'b011 -> GRANT=3'b001, then PTR=1. SEL_OUT never equals 3.
- REG_BUS_PRIO0_EN defined: REQ=4'b1001 held -> GRANT=0001 every cycle. Without the macro -> alternates 0001, 1000.
